sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the word width in bits.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 8, meaning log2 of the depth; DEPTH = 2**ADDRESS_WIDTH.
REQ-003 The block SHALL have parameter MODE, default FIFO_MODE_STANDARD, meaning the read mode: FIFO_MODE_STANDARD (registered read) or FIFO_MODE_FWFT (first-word-fall-through).
REQ-004 The block SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-1, meaning the count at or above which almost_full asserts.
REQ-005 The block SHALL have parameter ALMOST_EMPTY_LEVEL, default 1, meaning the count at or below which almost_empty asserts.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous flush.
REQ-009 The block SHALL have port write_data, input, DATA_WIDTH bits: the word to enqueue.
REQ-010 The block SHALL have port write_increment, input, 1 bit: the write request.
REQ-011 The block SHALL have port read_increment, input, 1 bit: the read request (STANDARD) or head acknowledge (FWFT).
REQ-012 The block SHALL have port read_data, output, DATA_WIDTH bits: the dequeued word.
REQ-013 The block SHALL have port read_valid, output, 1 bit: read_data holds a valid word this cycle.
REQ-014 The block SHALL have status outputs full, empty, almost_full and almost_empty, each 1 bit.
REQ-015 The block SHALL have port count, output, ADDRESS_WIDTH+1 bits: the number of stored words.
REQ-016 The block SHALL have sticky flags overflow and underflow, outputs, 1 bit each.

Function
REQ-017 Write acceptance SHALL be write_accept = write_increment & !full; an accepted write stores write_data at the write pointer.
REQ-018 Read acceptance SHALL be read_accept = read_increment & !empty.
REQ-019 The write and read pointers SHALL be ADDRESS_WIDTH+1-bit binary counters; each increments by 1 per accepted operation and wraps modulo 2**(ADDRESS_WIDTH+1).
REQ-020 count SHALL equal write pointer minus read pointer, modulo 2**(ADDRESS_WIDTH+1), range 0..DEPTH.
REQ-021 Flags SHALL follow count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=ALMOST_FULL_LEVEL), almost_empty = (count<=ALMOST_EMPTY_LEVEL).
REQ-022 All flags and count SHALL update one clock after the accepting edge.
REQ-023 A simultaneous write_accept and read_accept SHALL leave count unchanged and update both pointers.
REQ-024 When full, a write SHALL be rejected even if a read is accepted in the same cycle; there is no pass-through.
REQ-025 In STANDARD mode, on read_accept, read_data SHALL load the head word at the next edge and read_valid SHALL be high for exactly that one cycle.
REQ-026 In STANDARD mode, read_data SHALL hold its last value otherwise.
REQ-027 In FWFT mode, read_data SHALL present the head word combinationally whenever !empty, with read_valid = !empty; read_increment pops the head.
REQ-028 A write into an empty FIFO SHALL become visible (empty low) one cycle after the write edge, in both modes.
REQ-029 overflow SHALL set on write_increment & full; underflow SHALL set on read_increment & empty; both remain set until reset or clear.
REQ-030 clear SHALL zero both pointers, count, overflow, underflow and read_valid at the next edge.
REQ-031 clear SHALL take priority over any simultaneous write or read, which are discarded.
REQ-032 Memory contents SHALL be unaffected by clear.
REQ-033 Elaboration SHALL fail if ALMOST_FULL_LEVEL > DEPTH or ALMOST_EMPTY_LEVEL > DEPTH.

Reset
REQ-034 Asserting reset SHALL immediately force: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0 (unless ALMOST_FULL_LEVEL==0), overflow=0, underflow=0, read_valid=0, read_data=0.
REQ-035 Reset mid-operation SHALL discard all stored words; memory array is not reset.

Structure
REQ-036 The fifo_mode_t enum (FIFO_MODE_STANDARD, FIFO_MODE_FWFT) SHALL live in shared package sync_fifo_pkg.
REQ-037 Storage SHALL be one sub-module, sync_fifo_memory: a DEPTH x DATA_WIDTH array with synchronous write and combinational read.

Verification (DATA_WIDTH=8, ADDRESS_WIDTH=2, ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1)
REQ-038 Scenario: write 0x11,0x22,0x33,0x44 -> full=1 and count=4; a fifth write of 0x55 -> overflow=1 and count stays 4.
REQ-039 Scenario (STANDARD): from the state of REQ-038, read four words -> 0x11..0x44 in order, each with a one-cycle read_valid one cycle after its request; then empty=1.
REQ-040 Scenario (FWFT): write 0xA5 -> one cycle later read_data=0xA5 and read_valid=1 with no read request; pulse read_increment -> empty=1 the next cycle.
REQ-041 Scenario: with count=2, assert write and read together for 10 cycles -> count stays 2, data order is preserved, and pointers wrap past 7 to 0.
REQ-042 Scenario: count=3 with overflow set, assert clear together with write_increment -> next cycle count=0, empty=1, overflow=0, and the write is discarded.
REQ-043 Scenario: read_increment while empty -> underflow=1 and read_valid=0; then assert reset asynchronously mid-burst -> all outputs match REQ-034 before the next edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared read-mode type for sync_fifo
package sync_fifo_pkg;
  typedef enum logic {FIFO_MODE_STANDARD, FIFO_MODE_FWFT} fifo_mode_t;
endpackage

// File: rtl/sync_fifo_memory.sv
// sync_fifo_memory: DEPTH x DATA_WIDTH storage, synchronous write, combinational read
module sync_fifo_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     i_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] i_write_address,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  input  logic [ADDRESS_WIDTH-1:0] i_read_address,
  output logic [DATA_WIDTH-1:0]    o_read_data
);
  logic [DATA_WIDTH-1:0] r_memory [2**ADDRESS_WIDTH];
  // store the word; contents survive reset and clear by design
  always_ff @(posedge clock)
    if (i_write_enable) r_memory[i_write_address] <= i_write_data;
  assign o_read_data = r_memory[i_read_address];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered or first-word-fall-through read
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH         = 8,
  parameter int         ADDRESS_WIDTH      = 8,
  parameter fifo_mode_t MODE               = FIFO_MODE_STANDARD,
  parameter int         ALMOST_FULL_LEVEL  = (2 ** ADDRESS_WIDTH) - 1,
  parameter int         ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   write_increment,
  input  logic                   read_increment,
  output logic [DATA_WIDTH-1:0]  read_data,
  output logic                   read_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDRESS_WIDTH:0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] AF_C = (ADDRESS_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0] AE_C = (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);

  if (ALMOST_FULL_LEVEL > DEPTH || ALMOST_EMPTY_LEVEL > DEPTH) begin : g_level_check
    $error("sync_fifo: almost-full/almost-empty level exceeds DEPTH");
  end

  logic [ADDRESS_WIDTH:0]  r_write_pointer, r_read_pointer, w_count;
  logic [DATA_WIDTH-1:0]   r_read_data, w_head;
  logic                    r_read_valid, r_overflow, r_underflow;
  logic                    w_full, w_empty, w_write_accept, w_read_accept;

  assign w_count        = r_write_pointer - r_read_pointer;
  assign w_full         = w_count == DEPTH_C;
  assign w_empty        = w_count == '0;
  assign w_write_accept = write_increment & ~w_full;
  assign w_read_accept  = read_increment & ~w_empty;

  sync_fifo_memory #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_memory (
    .clock          (clock),
    .i_write_enable (w_write_accept & ~clear),
    .i_write_address(r_write_pointer[ADDRESS_WIDTH-1:0]),
    .i_write_data   (write_data),
    .i_read_address (r_read_pointer[ADDRESS_WIDTH-1:0]),
    .o_read_data    (w_head)
  );

  // pointers, sticky error flags and the registered read port; clear beats any request
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_write_pointer <= '0;
      r_read_pointer  <= '0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
      r_read_valid    <= 1'b0;
      r_read_data     <= '0;
    end else if (clear) begin
      r_write_pointer <= '0;
      r_read_pointer  <= '0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
      r_read_valid    <= 1'b0;
    end else begin
      r_write_pointer <= r_write_pointer + (ADDRESS_WIDTH + 1)'(w_write_accept);
      r_read_pointer  <= r_read_pointer + (ADDRESS_WIDTH + 1)'(w_read_accept);
      r_overflow      <= r_overflow | (write_increment & w_full);
      r_underflow     <= r_underflow | (read_increment & w_empty);
      r_read_valid    <= w_read_accept;
      r_read_data     <= w_read_accept ? w_head : r_read_data;
    end

  assign count        = w_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = w_count >= AF_C;
  assign almost_empty = w_count <= AE_C;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign read_data    = (MODE == FIFO_MODE_FWFT) ? (w_empty ? '0 : w_head) : r_read_data;
  assign read_valid   = (MODE == FIFO_MODE_FWFT) ? ~w_empty : r_read_valid;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: standard and FWFT instances driven in lockstep against a queue model
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic       clock = 1'b0, reset = 1'b0, clear = 1'b0;
  logic       write_increment = 1'b0, read_increment = 1'b0;
  logic [7:0] write_data = 8'h00;

  logic [7:0] s_rd, f_rd;
  logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] s_count, f_count;

  int checks = 0, fails = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  always #5 clock = ~clock;

  sync_fifo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(2), .MODE(FIFO_MODE_STANDARD),
              .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)) u_std (
    .clock(clock), .reset(reset), .clear(clear), .write_data(write_data),
    .write_increment(write_increment), .read_increment(read_increment),
    .read_data(s_rd), .read_valid(s_rv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf));

  sync_fifo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(2), .MODE(FIFO_MODE_FWFT),
              .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)) u_fwft (
    .clock(clock), .reset(reset), .clear(clear), .write_data(write_data),
    .write_increment(write_increment), .read_increment(read_increment),
    .read_data(f_rd), .read_valid(f_rv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  wire [35:0] got = {s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_count,
                     f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_count,
                     s_rv, s_rd, f_rv, f_rd};

  function automatic logic [35:0] exp_all();
    int n;
    logic [8:0] st;
    n = q.size();
    st = {n == 4, n == 0, n >= 3, n <= 1, m_ovf, m_unf, 3'(n)};
    return {st, st, m_rv, m_rd, n > 0, n > 0 ? q[0] : 8'h00};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_rv = 0;
    m_rd = 8'h00;
  endtask

  task automatic cycle(input bit wi, input bit ri, input bit clr, input logic [7:0] wd);
    int n;
    write_increment = wi;
    read_increment = ri;
    clear = clr;
    write_data = wd;
    @(posedge clock);
    #1;
    n = q.size();
    if (clr) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_rv = 0;
    end else begin
      m_ovf = m_ovf | (wi && n == 4);
      m_unf = m_unf | (ri && n == 0);
      m_rv = ri && n > 0;
      if (m_rv) m_rd = q.pop_front();
      if (wi && n < 4) q.push_back(wd);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    if (got !== exp_all()) begin
      fails++;
      $display("FAIL reset_model: got %h expected %h", got, exp_all());
    end
    checks++;
    if (got !== {9'b010100000, 9'b010100000, 1'b0, 8'h00, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset_const: got %h", got);
    end
    checks++;
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 8'((i + 1) * 17));
      if (got !== exp_all()) begin
        fails++;
        $display("FAIL fill_%0d: got %h expected %h", i, got, exp_all());
      end
      checks++;
    end
    if ({s_full, s_count, f_full, f_count} !== 8'b1100_1100) begin
      fails++;
      $display("FAIL fill_full: full/count std %b/%0d fwft %b/%0d, need 1/4", s_full, s_count, f_full, f_count);
    end
    checks++;
    cycle(1, 0, 0, 8'h55);
    if ({s_ovf, s_count, f_ovf, f_count} !== 8'b1100_1100) begin
      fails++;
      $display("FAIL overflow: ovf/count std %b/%0d fwft %b/%0d, need 1/4", s_ovf, s_count, f_ovf, f_count);
    end
    checks++;
  endtask

  task automatic test_std_read();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 8'h00);
      if ({s_rv, s_rd} !== {1'b1, 8'((i + 1) * 17)} || got !== exp_all()) begin
        fails++;
        $display("FAIL std_read_%0d: rv %b data %h, need 1 %h (all %h vs %h)", i, s_rv, s_rd, 8'((i + 1) * 17), got, exp_all());
      end
      checks++;
      cycle(0, 0, 0, 8'h00);
      if ({s_rv, s_rd} !== {1'b0, 8'((i + 1) * 17)}) begin
        fails++;
        $display("FAIL std_hold_%0d: rv %b data %h, need 0 %h", i, s_rv, s_rd, 8'((i + 1) * 17));
      end
      checks++;
    end
    if ({s_empty, f_empty} !== 2'b11) begin
      fails++;
      $display("FAIL std_drained: empty std %b fwft %b, need 1", s_empty, f_empty);
    end
    checks++;
  endtask

  task automatic test_fwft();
    cycle(1, 0, 0, 8'hA5);
    if ({f_rv, f_rd} !== {1'b1, 8'hA5} || got !== exp_all()) begin
      fails++;
      $display("FAIL fwft_show: rv %b data %h, need 1 a5", f_rv, f_rd);
    end
    checks++;
    cycle(0, 1, 0, 8'h00);
    if ({f_empty, f_rv} !== 2'b10 || got !== exp_all()) begin
      fails++;
      $display("FAIL fwft_pop: empty %b rv %b, need 1 0", f_empty, f_rv);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 0, 8'($urandom));
    cycle(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, 8'($urandom));
      if (s_count !== 3'd2 || got !== exp_all()) begin
        fails++;
        $display("FAIL b2b_%0d: count %0d need 2, all %h vs %h", i, s_count, got, exp_all());
      end
      checks++;
    end
  endtask

  task automatic test_clear();
    cycle(1, 0, 0, 8'h01);
    cycle(1, 0, 0, 8'h02);
    cycle(1, 0, 0, 8'h03);
    cycle(0, 1, 0, 8'h00);
    if ({s_count, s_ovf} !== 4'b011_1 || got !== exp_all()) begin
      fails++;
      $display("FAIL clear_setup: count %0d ovf %b, need 3 1", s_count, s_ovf);
    end
    checks++;
    cycle(1, 0, 1, 8'hEE);
    if ({s_count, s_empty, s_ovf, f_count, f_empty, f_rv} !== 10'b000_1_0_000_1_0 || got !== exp_all()) begin
      fails++;
      $display("FAIL clear: count %0d empty %b ovf %b, need 0 1 0", s_count, s_empty, s_ovf);
    end
    checks++;
    cycle(0, 0, 0, 8'h00);
    if (got !== exp_all()) begin
      fails++;
      $display("FAIL clear_discard: got %h expected %h", got, exp_all());
    end
    checks++;
  endtask

  task automatic test_underflow_reset();
    cycle(0, 1, 0, 8'h00);
    if ({s_unf, s_rv, f_unf, f_rv} !== 4'b1010 || got !== exp_all()) begin
      fails++;
      $display("FAIL underflow: unf %b rv %b, need 1 0", s_unf, s_rv);
    end
    checks++;
    cycle(1, 0, 0, 8'h5A);
    cycle(1, 1, 0, 8'h6B);
    write_increment = 1'b1;
    #3 reset = 1'b1;
    #1;
    model_reset();
    if (got !== {9'b010100000, 9'b010100000, 1'b0, 8'h00, 1'b0, 8'h00} || got !== exp_all()) begin
      fails++;
      $display("FAIL async_reset: got %h before next edge", got);
    end
    checks++;
    @(negedge clock);
    reset = 1'b0;
    write_increment = 1'b0;
    read_increment = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < (i < 200 ? 70 : 35),
            $urandom_range(0, 99) < (i < 200 ? 35 : 70),
            $urandom_range(0, 59) == 0, 8'($urandom));
      if (got !== exp_all()) begin
        fails++;
        $display("FAIL random_%0d: got %h expected %h", i, got, exp_all());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_std_read();
    test_fwft();
    test_back_to_back();
    test_clear();
    test_underflow_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
